// File: rtl/countdown_timer_ctrl.sv
// mm:ss BCD countdown timer controller: samples the 1 Hz / 100 Hz square waves as data,
// debounces start/clear on the 100 Hz tick and drives registered digits plus status.
module countdown_timer_ctrl #(
   parameter int DEB_SAMPLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_1,
   input  logic        clk_100,
   input  logic        btn_start,
   input  logic        btn_clear,
   input  logic [15:0] preset_bcd,
   output logic [15:0] digits,
   output logic        running,
   output logic        done,
   output logic        alarm_pulse,
   output logic        blink
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [15:0] sanitize_bcd(input logic [15:0] p);
      logic [3:0] mt, mu, st, su;
      mt = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
      mu = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
      st = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
      su = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
      return {mt, mu, st, su};
   endfunction

   // 00:00 is returned unchanged so the borrow chain never wraps min_tens.
   function automatic logic [15:0] bcd_decrement(input logic [15:0] d);
      logic [3:0] mt, mu, st, su;
      mt = d[15:12];
      mu = d[11:8];
      st = d[7:4];
      su = d[3:0];
      if (d == 16'h0000) begin
         su = 4'd0;
      end else if (su != 4'd0) begin
         su = su - 4'd1;
      end else begin
         su = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mu != 4'd0) begin
               mu = mu - 4'd1;
            end else begin
               mu = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mu, st, su};
   endfunction

   function automatic logic deb_level(input logic [DEB_SAMPLES-1:0] sh, input logic cur);
      if (&sh) begin
         return 1'b1;
      end else if (~|sh) begin
         return 1'b0;
      end else begin
         return cur;
      end
   endfunction

   // bit 0 = s1, bit 1 = s2, bit 2 = s3 (previous value)
   logic [2:0]             clk1_sync_r, clk100_sync_r, start_sync_r, clear_sync_r;
   logic [DEB_SAMPLES-1:0] start_shift_r, clear_shift_r;
   logic                   start_level_r, clear_level_r, start_prev_r, clear_prev_r;
   logic [DEB_SAMPLES-1:0] start_shift_next_s, clear_shift_next_s;
   logic                   tick_1_s, tick_100_s, start_press_s, clear_press_s;
   logic [15:0]            preset_san_s, dec_s;
   state_t                 state_r;
   logic [15:0]            digits_r;
   logic                   running_r, done_r, alarm_r, blink_r;

   assign tick_1_s           = clk1_sync_r[1] & ~clk1_sync_r[2];
   assign tick_100_s         = clk100_sync_r[1] & ~clk100_sync_r[2];
   assign start_shift_next_s = {start_shift_r[DEB_SAMPLES-2:0], start_sync_r[2]};
   assign clear_shift_next_s = {clear_shift_r[DEB_SAMPLES-2:0], clear_sync_r[2]};
   assign start_press_s      = start_level_r & ~start_prev_r;
   assign clear_press_s      = clear_level_r & ~clear_prev_r;
   assign preset_san_s       = sanitize_bcd(preset_bcd);
   assign dec_s              = bcd_decrement(digits_r);

   // Two-stage synchronisers plus previous-value flop for every asynchronous input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk1_sync_r   <= 3'b000;
         clk100_sync_r <= 3'b000;
         start_sync_r  <= 3'b000;
         clear_sync_r  <= 3'b000;
      end else begin
         clk1_sync_r   <= {clk1_sync_r[1], clk1_sync_r[0], clk_1};
         clk100_sync_r <= {clk100_sync_r[1], clk100_sync_r[0], clk_100};
         start_sync_r  <= {start_sync_r[1], start_sync_r[0], btn_start};
         clear_sync_r  <= {clear_sync_r[1], clear_sync_r[0], btn_clear};
      end
   end

   // Button debounce sampled on the 100 Hz tick; press is the rising edge of the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_shift_r <= '0;
         clear_shift_r <= '0;
         start_level_r <= 1'b0;
         clear_level_r <= 1'b0;
         start_prev_r  <= 1'b0;
         clear_prev_r  <= 1'b0;
      end else begin
         if (tick_100_s) begin
            start_shift_r <= start_shift_next_s;
            clear_shift_r <= clear_shift_next_s;
            start_level_r <= deb_level(start_shift_next_s, start_level_r);
            clear_level_r <= deb_level(clear_shift_next_s, clear_level_r);
         end else begin
            start_shift_r <= start_shift_r;
            clear_shift_r <= clear_shift_r;
            start_level_r <= start_level_r;
            clear_level_r <= clear_level_r;
         end
         start_prev_r <= start_level_r;
         clear_prev_r <= clear_level_r;
      end
   end

   // Timer FSM with registered outputs decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         digits_r  <= 16'h0000;
         running_r <= 1'b0;
         done_r    <= 1'b0;
         alarm_r   <= 1'b0;
         blink_r   <= 1'b1;
      end else begin
         alarm_r <= 1'b0;
         case (state_r)
            IDLE: begin
               digits_r <= preset_san_s;
               done_r   <= 1'b0;
               blink_r  <= 1'b1;
               if (start_press_s && !clear_press_s && (preset_san_s != 16'h0000)) begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
               end else begin
                  state_r   <= IDLE;
                  running_r <= 1'b0;
               end
            end
            RUN: begin
               if (clear_press_s) begin
                  state_r   <= IDLE;
                  digits_r  <= preset_san_s;
                  running_r <= 1'b0;
               end else if (tick_1_s && (dec_s == 16'h0000)) begin
                  state_r   <= DONE;
                  digits_r  <= 16'h0000;
                  running_r <= 1'b0;
                  done_r    <= 1'b1;
                  alarm_r   <= 1'b1;
                  blink_r   <= 1'b1;
               end else begin
                  digits_r <= tick_1_s ? dec_s : digits_r;
                  if (start_press_s) begin
                     state_r   <= PAUSE;
                     running_r <= 1'b0;
                  end else begin
                     state_r   <= RUN;
                     running_r <= 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (clear_press_s) begin
                  state_r  <= IDLE;
                  digits_r <= preset_san_s;
               end else if (start_press_s) begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
               end else begin
                  state_r <= PAUSE;
               end
            end
            DONE: begin
               digits_r <= 16'h0000;
               if (clear_press_s) begin
                  state_r  <= IDLE;
                  digits_r <= preset_san_s;
                  done_r   <= 1'b0;
                  blink_r  <= 1'b1;
               end else if (tick_1_s) begin
                  blink_r <= ~blink_r;
               end else begin
                  blink_r <= blink_r;
               end
            end
            default: begin
               state_r   <= IDLE;
               digits_r  <= 16'h0000;
               running_r <= 1'b0;
               done_r    <= 1'b0;
               blink_r   <= 1'b1;
            end
         endcase
      end
   end

   assign digits      = digits_r;
   assign running     = running_r;
   assign done        = done_r;
   assign alarm_pulse = alarm_r;
   assign blink       = blink_r;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl; the slow square waves are
// emulated with short pulses of a few clk cycles.
`timescale 1ns/1ps
module tb_countdown_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst, clk_1, clk_100, btn_start, btn_clear;
   logic [15:0] preset_bcd, digits;
   logic        running, done, alarm_pulse, blink;
   int          errors = 0, checks = 0, alarm_cnt = 0, rise_cnt = 0;
   int          a0, r0;
   logic        run_prev = 1'b0;

   countdown_timer_ctrl #(.DEB_SAMPLES(4)) dut (
      .clk(clk), .rst(rst), .clk_1(clk_1), .clk_100(clk_100),
      .btn_start(btn_start), .btn_clear(btn_clear), .preset_bcd(preset_bcd),
      .digits(digits), .running(running), .done(done),
      .alarm_pulse(alarm_pulse), .blink(blink)
   );

   always #12.5 clk = ~clk;

   // Counts alarm pulse cycles and rising edges of running.
   always @(posedge clk) begin
      if (alarm_pulse) alarm_cnt <= alarm_cnt + 1;
      if (running && !run_prev) rise_cnt <= rise_cnt + 1;
      run_prev <= running;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse100();
      @(negedge clk) clk_100 = 1'b1;
      repeat (4) @(negedge clk);
      clk_100 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse1();
      @(negedge clk) clk_1 = 1'b1;
      repeat (4) @(negedge clk);
      clk_1 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic press(input logic s, input logic c);
      btn_start = s; btn_clear = c;
      repeat (4) @(negedge clk);
      repeat (4) pulse100();
      btn_start = 1'b0; btn_clear = 1'b0;
      repeat (4) @(negedge clk);
      repeat (4) pulse100();
   endtask

   // Press lands on the same clk cycle as a tick_1 (clk_1 rises one clk after clk_100).
   task automatic press_tick(input logic s, input logic c);
      btn_start = s; btn_clear = c;
      repeat (4) @(negedge clk);
      repeat (3) pulse100();
      @(negedge clk) clk_100 = 1'b1;
      @(negedge clk) clk_1 = 1'b1;
      repeat (4) @(negedge clk);
      clk_100 = 1'b0; clk_1 = 1'b0;
      repeat (4) @(negedge clk);
      btn_start = 1'b0; btn_clear = 1'b0;
      repeat (4) @(negedge clk);
      repeat (4) pulse100();
   endtask

   task automatic bounce_sample(input logic b);
      btn_start = b;
      repeat (4) @(negedge clk);
      pulse100();
   endtask

   initial begin
      rst = 1'b1; clk_1 = 1'b0; clk_100 = 1'b0;
      btn_start = 1'b0; btn_clear = 1'b0; preset_bcd = 16'h0130;
      repeat (3) @(negedge clk);
      check("rst_digits", digits, 16'h0000);
      check("rst_running", {15'd0, running}, 16'd0);
      check("rst_done", {15'd0, done}, 16'd0);
      check("rst_alarm", {15'd0, alarm_pulse}, 16'd0);
      check("rst_blink", {15'd0, blink}, 16'd1);
      rst = 1'b0;
      @(negedge clk);
      check("idle_load", digits, 16'h0130);

      // Basic countdown
      press(1'b1, 1'b0);
      check("start_running", {15'd0, running}, 16'd1);
      repeat (3) pulse1();
      check("count_3s", digits, 16'h0127);
      press(1'b0, 1'b1);
      check("clear_running", {15'd0, running}, 16'd0);
      check("clear_reload", digits, 16'h0130);

      // Expiry, alarm and blink
      preset_bcd = 16'h0001;
      repeat (2) @(negedge clk);
      a0 = alarm_cnt;
      press(1'b1, 1'b0);
      pulse1();
      check("exp_digits", digits, 16'h0000);
      check("exp_done", {15'd0, done}, 16'd1);
      check("exp_running", {15'd0, running}, 16'd0);
      check("exp_alarm_cnt", 16'(alarm_cnt - a0), 16'd1);
      check("exp_blink0", {15'd0, blink}, 16'd1);
      pulse1(); check("blink_1", {15'd0, blink}, 16'd0);
      pulse1(); check("blink_2", {15'd0, blink}, 16'd1);
      pulse1(); check("blink_3", {15'd0, blink}, 16'd0);
      pulse1(); check("blink_4", {15'd0, blink}, 16'd1);
      check("done_hold", digits, 16'h0000);
      press(1'b1, 1'b0);
      check("done_start_ign", {15'd0, done}, 16'd1);
      press(1'b0, 1'b1);
      check("done_clear", {15'd0, done}, 16'd0);
      check("done_clear_blink", {15'd0, blink}, 16'd1);

      // Borrow chain and pause
      preset_bcd = 16'h1000;
      repeat (2) @(negedge clk);
      press(1'b1, 1'b0);
      pulse1();
      check("borrow_0959", digits, 16'h0959);
      press(1'b1, 1'b0);
      check("pause_running", {15'd0, running}, 16'd0);
      repeat (5) pulse1();
      check("pause_frozen", digits, 16'h0959);
      press(1'b1, 1'b0);
      check("resume_running", {15'd0, running}, 16'd1);
      pulse1();
      check("resume_count", digits, 16'h0958);
      press(1'b0, 1'b1);

      // Bounce rejection
      preset_bcd = 16'h0130;
      repeat (2) @(negedge clk);
      r0 = rise_cnt;
      bounce_sample(1'b1); bounce_sample(1'b0);
      bounce_sample(1'b1); bounce_sample(1'b0);
      check("bounce_no_run", {15'd0, running}, 16'd0);
      check("bounce_no_rise", 16'(rise_cnt - r0), 16'd0);
      repeat (4) bounce_sample(1'b1);
      bounce_sample(1'b0);
      repeat (4) bounce_sample(1'b0);
      check("stable_run", {15'd0, running}, 16'd1);
      check("stable_one_rise", 16'(rise_cnt - r0), 16'd1);
      press(1'b0, 1'b1);

      // Sanitising and zero preset
      preset_bcd = 16'hFF7A;
      repeat (2) @(negedge clk);
      check("sanitise", digits, 16'h9959);
      preset_bcd = 16'h0000;
      repeat (2) @(negedge clk);
      press(1'b1, 1'b0);
      check("zero_no_run", {15'd0, running}, 16'd0);
      check("zero_digits", digits, 16'h0000);

      // Coincident events
      preset_bcd = 16'h0130;
      repeat (2) @(negedge clk);
      press(1'b1, 1'b0);
      press_tick(1'b1, 1'b0);
      check("tick_start_dec", digits, 16'h0129);
      check("tick_start_pause", {15'd0, running}, 16'd0);
      press(1'b1, 1'b0);
      check("tick_start_resume", {15'd0, running}, 16'd1);
      press_tick(1'b1, 1'b1);
      check("clr_wins_running", {15'd0, running}, 16'd0);
      check("clr_wins_reload", digits, 16'h0130);
      preset_bcd = 16'h0245;
      repeat (2) @(negedge clk);
      check("clr_wins_idle", digits, 16'h0245);

      // Reset mid-count
      press(1'b1, 1'b0);
      pulse1();
      check("pre_rst_count", digits, 16'h0244);
      @(negedge clk) rst = 1'b1;
      #1;
      check("midrst_digits", digits, 16'h0000);
      check("midrst_running", {15'd0, running}, 16'd0);
      check("midrst_done", {15'd0, done}, 16'd0);
      check("midrst_alarm", {15'd0, alarm_pulse}, 16'd0);
      check("midrst_blink", {15'd0, blink}, 16'd1);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("post_rst_reload", digits, 16'h0245);
      check("post_rst_running", {15'd0, running}, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- mm:ss BCD countdown timer with start/pause and clear push-buttons, running in the 40 MHz clk domain.
- Consumes the divided clk_1 (1 Hz) and clk_100 (100 Hz) square waves from the clock generator as plain data levels, never as clocks.
- Converts their rising edges into single-cycle ticks, debounces the buttons on the 100 Hz tick, and drives BCD digits plus status to the display stage.

Parameters:
- DEB_SAMPLES, 4: number of consecutive equal 100 Hz samples needed to change a debounced button level.

Ports:
- clk, input, 1: system clock, 40 MHz.
- rst, input, 1: reset, asynchronous, active-high.
- clk_1, input, 1: 1 Hz square wave from the clock generator.
- clk_100, input, 1: 100 Hz square wave from the clock generator.
- btn_start, input, 1: raw start/pause button, active-high, asynchronous.
- btn_clear, input, 1: raw clear button, active-high, asynchronous.
- preset_bcd, input, 16: preset mm:ss as {min_tens, min_units, sec_tens, sec_units}.
- digits, output, 16: current mm:ss BCD value, same packing as preset_bcd.
- running, output, 1: high in RUN.
- done, output, 1: high in DONE.
- alarm_pulse, output, 1: one-clk pulse on expiry.
- blink, output, 1: display-enable blink, 1 outside DONE.

Behaviour:
- Reset (async): state IDLE; digits=16'h0000; running=0; done=0; alarm_pulse=0; blink=1; all sync, edge and debounce flops=0.
- Synchronisers:
  - clk_1, clk_100, btn_start and btn_clear each pass through 2 flops (s1, s2), plus a previous-value flop s3.
  - tick = s2 & ~s3. It is high for exactly one clk cycle and acted on at the 3rd clk edge after the input rises.
  - A falling edge produces no tick.
- Debounce:
  - On each tick_100, shift the synced button into a DEB_SAMPLES-bit register.
  - Debounced level goes to 1 when all bits are 1, to 0 when all bits are 0; otherwise it holds.
  - press = rising edge of the debounced level, one clk cycle wide.
- Preset sanitising, per digit:
  - min_tens >9 -> 9.
  - min_units >9 -> 9.
  - sec_tens >5 -> 5.
  - sec_units >9 -> 9.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: digits is loaded with the sanitised preset every cycle. start_press with sanitised preset !=0000 -> RUN. start_press with preset 0000 -> stay IDLE.
  - RUN: each tick_1 decrements digits. A decrement that results in 0000 -> DONE, with alarm_pulse=1 for that same cycle (registered). start_press -> PAUSE. clear_press -> IDLE.
  - PAUSE: digits frozen. start_press -> RUN. clear_press -> IDLE.
  - DONE: digits hold 0000. blink toggles on each tick_1, starting from 1. start_press ignored. clear_press -> IDLE with blink=1.
- Priority and simultaneous events:
  - clear_press beats start_press in the same cycle.
  - tick_1 together with start_press in RUN: the decrement is applied and the state goes to PAUSE.
  - tick_1 together with clear_press: clear wins and there is no decrement.
- The first second after start is partial: the first tick_1 after entry to RUN decrements. This is accepted by design.
- BCD decrement with borrow chain:
  - sec_units 0 -> 9 and borrow.
  - sec_tens 0 -> 5 and borrow.
  - min_units 0 -> 9 and borrow.
  - min_tens decrements.
  - Examples: 10:00 -> 09:59; 01:00 -> 00:59.
  - 00:00 is never decremented.
- running and done are registered, decoded from the next state, and valid in the same cycle as the state.
- Reset mid-count returns to IDLE with digits 0000. Digits reload from preset one clk later.
- Pulse widths: clk_1 and clk_100 must stay high/low for ≥3 clk cycles; shorter pulses may be missed.

Test Plan:
- Reset, then preset_bcd=16'h0130, then one clean start press (held ≥DEB_SAMPLES tick_100) -> running=1; after 3 tick_1, digits=16'h0127.
- preset 16'h0001, start, then 1 tick_1 -> digits=0000, done=1, alarm_pulse high for exactly 1 clk; 4 further tick_1 -> blink sequence 0,1,0,1.
- preset 16'h1000, start, then 1 tick_1 -> digits=16'h0959. Then start press -> PAUSE; 5 tick_1 -> digits stays 16'h0959. Then start press -> RUN resumes.
- btn_start bouncing 1,0,1,0 across consecutive tick_100, then stable 1 for 4 ticks -> exactly one start_press and one transition; bounce alone -> no transition.
- preset 16'hFF7A -> digits in IDLE=16'h9959. Preset 0000 plus start -> stays IDLE, running=0.
- In RUN: clear and start pressed in the same cycle, with tick_1 coincident -> IDLE, digits reload from preset with no decrement. Assert rst mid-RUN -> all outputs at reset values immediately.
